// File: rtl/load_store_unit.sv
// load_store_unit: sequences RV32I loads/stores into an edge-triggered byte memory.
// Faulting requests skip memory and report after a one-cycle wait in CAPTURE.
module load_store_unit #(
  parameter int MEM_BYTES = 10
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_misaligned_o,
  output logic        resp_fault_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_write_enable_o,
  output logic        mem_read_enable_o,
  output logic [2:0]  mem_type_o,
  input  logic [31:0] mem_read_data_i
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_t;
  state_t      state_q, state_d;
  logic        store_q, store_d, mis_q, mis_d, flt_q, flt_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d, resp_flt_q, resp_flt_d;
  logic [31:0] mem_address_q, mem_address_d, mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [2:0]  mem_type_q, mem_type_d;
  logic [2:0]  f, typ, size;
  logic        illegal, mis, rng, bad;
  logic [32:0] end_addr;
  assign f        = req_funct3_i;
  assign illegal  = req_store_i ? (f[2] | (f[1:0] == 2'b11)) : ((f[1:0] == 2'b11) | (f[2] & f[1]));
  assign typ      = {f[2], f[1] | (f[2] & f[0]), f[0] & ~f[2]};
  assign size     = f[1] ? 3'd4 : f[0] ? 3'd2 : 3'd1;
  assign mis      = (f[0] & req_addr_i[0]) | (f[1] & (req_addr_i[1:0] != 2'b00));
  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign end_addr = {1'b0, req_addr_i} + {30'd0, size};
  assign rng      = end_addr > 33'(MEM_BYTES);
  assign bad      = illegal | mis | rng;
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    mis_d         = mis_q;
    flt_d         = flt_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_mis_d    = resp_mis_q;
    resp_flt_d    = resp_flt_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_type_d    = mem_type_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        store_d       = req_store_i;
        mis_d         = ~illegal & mis;
        flt_d         = illegal | (~mis & rng);
        req_ready_d   = 1'b0;
        state_d       = bad ? CAPTURE : SETUP;
        mem_address_d = bad ? 32'd0 : req_addr_i;
        mem_wdata_d   = bad ? 32'd0 : req_wdata_i;
        mem_type_d    = bad ? 3'd0 : typ;
      end
      SETUP: begin
        state_d  = STROBE;
        mem_we_d = store_q;
        mem_re_d = ~store_q;
      end
      STROBE: state_d = CAPTURE;
      CAPTURE: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_rdata_d  = (store_q | mis_q | flt_q) ? 32'd0 : mem_read_data_i;
        resp_mis_d    = mis_q;
        resp_flt_d    = flt_q;
        mem_address_d = 32'd0;
        mem_wdata_d   = 32'd0;
        mem_type_d    = 3'd0;
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        resp_mis_d   = 1'b0;
        resp_flt_d   = 1'b0;
        req_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      store_q       <= 1'b0;
      mis_q         <= 1'b0;
      flt_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_mis_q    <= 1'b0;
      resp_flt_q    <= 1'b0;
      mem_address_q <= 32'd0;
      mem_wdata_q   <= 32'd0;
      mem_type_q    <= 3'd0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      mis_q         <= mis_d;
      flt_q         <= flt_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_mis_q    <= resp_mis_d;
      resp_flt_q    <= resp_flt_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_type_q    <= mem_type_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
    end
  end
  assign req_ready_o        = req_ready_q;
  assign resp_valid_o       = resp_valid_q;
  assign resp_rdata_o       = resp_rdata_q;
  assign resp_misaligned_o  = resp_mis_q;
  assign resp_fault_o       = resp_flt_q;
  assign mem_address_o      = mem_address_q;
  assign mem_write_data_o   = mem_wdata_q;
  assign mem_write_enable_o = mem_we_q;
  assign mem_read_enable_o  = mem_re_q;
  assign mem_type_o         = mem_type_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against an edge-triggered byte memory model.
module tb_load_store_unit;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_mis, resp_flt, mem_we, mem_re;
  logic [31:0] resp_rdata, mem_address, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [2:0]  mem_type;
  logic [7:0]  mem [10];
  int          checks = 0, errors = 0, wcnt = 0, rcnt = 0;
  logic [2:0]  last_type = 0;
  logic        prev_en = 0;

  load_store_unit #(.MEM_BYTES(10)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_store_i(req_store),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_misaligned_o(resp_mis), .resp_fault_o(resp_flt), .mem_address_o(mem_address),
    .mem_write_data_o(mem_wdata), .mem_write_enable_o(mem_we), .mem_read_enable_o(mem_re),
    .mem_type_o(mem_type), .mem_read_data_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [31:0] a);
    return (a < 10) ? mem[a] : 8'h00;
  endfunction

  always @(posedge mem_we) begin
    wcnt++;
    last_type = mem_type;
    if (mem_address < 10) mem[mem_address] = mem_wdata[7:0];
    if (mem_type[1:0] != 2'b00 && mem_address + 1 < 10) mem[mem_address + 1] = mem_wdata[15:8];
    if (mem_type[1:0] == 2'b10) begin
      if (mem_address + 2 < 10) mem[mem_address + 2] = mem_wdata[23:16];
      if (mem_address + 3 < 10) mem[mem_address + 3] = mem_wdata[31:24];
    end
  end

  always @(posedge mem_re) begin
    logic [7:0] b0, b1, b2, b3;
    rcnt++;
    last_type = mem_type;
    b0 = rb(mem_address); b1 = rb(mem_address + 1);
    b2 = rb(mem_address + 2); b3 = rb(mem_address + 3);
    case (mem_type)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b100:  mem_rdata = {24'd0, b0};
      3'b110:  mem_rdata = {16'd0, b1, b0};
      default: mem_rdata = 32'hBAD0BAD0;
    endcase
  end

  always @(negedge clk) begin
    if (mem_we | mem_re) begin
      chk("en_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      chk("en_consecutive", {31'd0, prev_en}, 32'd0);
    end
    prev_en <= mem_we | mem_re;
  end

  task automatic req(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int elat, input logic [31:0] erd,
                     input logic emis, input logic eflt, input logic [2:0] etyp);
    int lat, w0, r0;
    logic clean;
    clean = !(emis | eflt);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    w0 = wcnt; r0 = rcnt;
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_rdata"}, resp_rdata, erd);
    chk({tag, "_misaligned"}, {31'd0, resp_mis}, {31'd0, emis});
    chk({tag, "_fault"}, {31'd0, resp_flt}, {31'd0, eflt});
    chk({tag, "_writes"}, wcnt - w0, (clean && st) ? 1 : 0);
    chk({tag, "_reads"}, rcnt - r0, (clean && !st) ? 1 : 0);
    if (clean) chk({tag, "_mem_type"}, {29'd0, last_type}, {29'd0, etyp});
    @(posedge clk); #1;
    chk({tag, "_resp_drop"}, {resp_valid, resp_mis, resp_flt, req_ready}, 4'b0001);
    chk({tag, "_rdata_clr"}, resp_rdata, 32'd0);
  endtask

  initial begin
    logic seen;
    for (int i = 0; i < 10; i++) mem[i] = 8'h00;
    #12;
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_outs", {resp_valid, resp_mis, resp_flt, mem_we, mem_re, mem_type}, 8'd0);
    chk("reset_addr", mem_address, 32'd0);
    @(negedge clk); reset = 0;
    req("sw4",   1, 3'b010, 32'd4, 32'hDEADBEEF, 4, 32'h0, 0, 0, 3'b010);
    req("lw4",   0, 3'b010, 32'd4, 32'h0, 4, 32'hDEADBEEF, 0, 0, 3'b010);
    req("sb0",   1, 3'b000, 32'd0, 32'h00000080, 4, 32'h0, 0, 0, 3'b000);
    req("lb0",   0, 3'b000, 32'd0, 32'h0, 4, 32'hFFFFFF80, 0, 0, 3'b000);
    req("lbu0",  0, 3'b100, 32'd0, 32'h0, 4, 32'h00000080, 0, 0, 3'b100);
    req("sh2",   1, 3'b001, 32'd2, 32'h00008001, 4, 32'h0, 0, 0, 3'b001);
    req("lhu2",  0, 3'b101, 32'd2, 32'h0, 4, 32'h00008001, 0, 0, 3'b110);
    req("lh2",   0, 3'b001, 32'd2, 32'h0, 4, 32'hFFFF8001, 0, 0, 3'b001);
    req("lw1",   0, 3'b010, 32'd1, 32'h0, 2, 32'h0, 1, 0, 3'b000);
    req("lh9",   0, 3'b001, 32'd9, 32'h0, 2, 32'h0, 1, 0, 3'b000);
    req("lw8",   0, 3'b010, 32'd8, 32'h0, 2, 32'h0, 0, 1, 3'b000);
    req("ld011", 0, 3'b011, 32'd0, 32'h0, 2, 32'h0, 0, 1, 3'b000);
    req("ill1",  0, 3'b011, 32'd1, 32'h0, 2, 32'h0, 0, 1, 3'b000);
    req("st100", 1, 3'b100, 32'd0, 32'h0, 2, 32'h0, 0, 1, 3'b000);
    req("sw6",   1, 3'b010, 32'd6, 32'h12345678, 2, 32'h0, 1, 0, 3'b000);
    req("sh8",   1, 3'b001, 32'd8, 32'hAAAA1234, 4, 32'h0, 0, 0, 3'b001);
    req("lhu8",  0, 3'b101, 32'd8, 32'h0, 4, 32'h00001234, 0, 0, 3'b110);
    req("lb9",   0, 3'b000, 32'd9, 32'h0, 4, 32'h00000012, 0, 0, 3'b000);
    req("lbwrap",0, 3'b000, 32'hFFFFFFFF, 32'h0, 2, 32'h0, 0, 1, 3'b000);
    req("lw4b",  0, 3'b010, 32'd4, 32'h0, 4, 32'hDEADBEEF, 0, 0, 3'b010);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'b010; req_addr = 0; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 0;
    chk("setup_type", {29'd0, mem_type}, 32'd2);
    chk("setup_wdata", mem_wdata, 32'h11223344);
    chk("setup_enables", {30'd0, mem_we, mem_re}, 32'd0);
    reset = 1; #1;
    chk("rst_mid_outs", {req_ready, resp_valid, mem_we, mem_re, mem_type}, 7'b1000000);
    chk("rst_mid_wdata", mem_wdata, 32'd0);
    @(posedge clk); @(negedge clk); reset = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | resp_valid | mem_we | mem_re;
    end
    chk("rst_no_activity", {31'd0, seen}, 32'd0);
    chk("rst_mem_unchanged", {mem[3], mem[2], mem[1], mem[0]}, 32'h80010080);
    req("lbu0b", 0, 3'b100, 32'd0, 32'h0, 4, 32'h00000080, 0, 0, 3'b100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
